// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch (I) and the
// memory stage (D). D has priority; a streak counter bounds how long a pending I waits.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   output logic                  if_ready_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [DATA_WIDTH-1:0] dm_wdata_i,
   output logic [DATA_WIDTH-1:0] dm_rdata_o,
   output logic                  dm_ready_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_ack_i,
   output logic                  stall_f_o,
   output logic                  stall_m_o
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   state_t                state_q, state_d;
   logic [3:0]            streak_q, streak_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
   logic                  if_ready_q, if_ready_d;
   logic                  dm_ready_q, dm_ready_d;
   logic                  i_elig, d_elig, grant_d, grant_i;

   function automatic logic [3:0] streak_sat_inc(input logic [3:0] s);
      return (s >= STREAK_MAX) ? STREAK_MAX : s + 4'd1;
   endfunction

   // A request still held during its own ready pulse is stale and must not win again.
   assign i_elig  = if_req_i & ~if_ready_q;
   assign d_elig  = dm_req_i & ~dm_ready_q;
   assign grant_d = d_elig & (~i_elig | (streak_q < STREAK_MAX));
   assign grant_i = i_elig & ~grant_d;

   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_ready_d  = 1'b0;
      dm_ready_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we_i;
               mem_addr_d  = dm_addr_i;
               mem_wdata_d = dm_wdata_i;
               streak_d    = i_elig ? streak_sat_inc(streak_q) : 4'd0;
            end else if (grant_i) begin
               state_d     = BUSY_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr_i;
               mem_wdata_d = '0;
               streak_d    = 4'd0;
            end
         end
         BUSY_I: begin
            if (mem_ack_i) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               if_ready_d = 1'b1;
               if_rdata_d = mem_rdata_i;
            end
         end
         BUSY_D: begin
            if (mem_ack_i) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               dm_ready_d = 1'b1;
               if (!mem_we_q) dm_rdata_d = mem_rdata_i;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         streak_q    <= 4'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign if_ready_o  = if_ready_q;
   assign dm_ready_o  = dm_ready_q;
   assign stall_f_o   = if_req_i & ~if_ready_q;
   assign stall_m_o   = dm_req_i & ~dm_ready_q;

endmodule
